laser_driver_mc: RTL and testbench
==================================

// Module: laser_driver_mc
// PURPOSE
//  Multi-channel laser driver: per-channel PWM, single-pulse and CW modes behind a global arm/interlock/watchdog FSM.
//  Successor to the single-channel driver: latched faults, host watchdog, pulse-done handshake, exact 100% duty.
//  Sits between the host register block and the laser GPIO pads; every emitter output passes through this block.
// PARAMETERS
//  NUM_CH     4      number of laser channels
//  PWM_W      8      PWM counter/duty width; PWM period = 2**PWM_W clk cycles
//  PULSE_W    32     pulse-length counter width (clk cycles)
//  WD_CYCLES  100000 watchdog timeout in clk cycles while ARMED; 0 disables watchdog
// PORTS
//  clk            in   1              system clock
//  reset          in   1              synchronous, active-high
//  interlock_safe in   1              1 = interlock closed (safe)
//  arm            in   1              level; request ARMED
//  fault_clear    in   1              pulse; clears latched fault
//  wd_kick        in   1              pulse; restarts watchdog
//  ch_mode        in   2*NUM_CH       per channel: 00 OFF, 01 PWM, 10 PULSE, 11 CW
//  ch_duty        in   PWM_W*NUM_CH   per-channel PWM duty
//  pulse_start    in   NUM_CH         per-channel pulse request (level, sampled when idle)
//  pulse_len      in   PULSE_W*NUM_CH per-channel pulse length
//  laser_out      out  NUM_CH         gated emitter drive
//  pulse_busy     out  NUM_CH         pulse in progress
//  pulse_done     out  NUM_CH         1-cycle strobe at normal pulse completion
//  armed          out  1              global FSM in ARMED
//  fault          out  1              global FSM in FAULT
//  fault_code     out  2              00 none, 01 interlock, 10 watchdog; held while FAULT
// BEHAVIOUR
//  Reset: all outputs 0; FSM DISARMED; PWM counter, watchdog, pulse counters 0. Reset mid-pulse aborts, no pulse_done.
//  Global FSM (registered): DISARMED -> ARMED when arm & interlock_safe.
//   ARMED -> DISARMED when !arm; ARMED -> FAULT when !interlock_safe (code 01) or watchdog expiry (code 10);
//   both same cycle -> code 01. FAULT -> DISARMED when fault_clear & interlock_safe; arm ignored in FAULT.
//  Output gating: laser_out = ch_raw & {NUM_CH{armed & interlock_safe}}, combinational on interlock_safe:
//   interlock drop forces laser_out=0 in the same cycle, before the FSM registers FAULT.
//  Watchdog: counts only in ARMED, cleared on entry to ARMED and on wd_kick; reaching WD_CYCLES-1 with no kick
//   -> FAULT next edge. wd_kick on the expiry cycle wins (no fault).
//  PWM: one shared free-running PWM_W counter, wraps 2**PWM_W-1 -> 0. ch_raw = (cnt < duty) registered (1-cycle latency);
//   duty 0 -> constant 0; duty all-ones -> constant 1 (true 100%).
//  CW: ch_raw = 1. OFF: ch_raw = 0.
//  PULSE: idle & pulse_start & armed -> load pulse_len, busy=1; ch_raw high exactly pulse_len cycles starting the cycle
//   after acceptance; on final cycle busy drops and pulse_done strobes 1 cycle. pulse_len 0 -> no high cycles,
//   busy for 1 cycle then pulse_done. pulse_start while busy ignored; held high after done -> new pulse next idle cycle.
//  Abort: leaving ARMED, mode change, or reset while busy -> busy=0, ch_raw=0 next edge, pulse_done NOT asserted.
//  Mode change takes effect on the next edge; channels fully independent apart from the shared PWM counter.
// STRUCTURE
//  laser_pkg: mode encodings (MODE_OFF/PWM/PULSE/CW), fault codes, FSM state enum.
//  Sub-module laser_channel (one per channel, generate loop): mode mux, PWM compare, pulse counter/handshake.
//  Top: global FSM, watchdog, shared PWM counter, output gating.
// TESTING
//  1 interlock_safe=0, arm=1, ch0 CW -> armed stays 0, laser_out=0 throughout.
//  2 armed, ch0 PWM duty=64, PWM_W=8 -> exactly 64 high of every 256 cycles; duty=255 -> 256/256; duty=0 -> 0/256.
//  3 armed, ch1 PULSE len=1000 -> laser_out[1] high exactly 1000 cycles, pulse_done 1 cycle at end; len=0 -> done, no high.
//  4 ch0 CW, mid-pulse on ch1, drop interlock_safe -> laser_out=0 same cycle, fault=1 code 01, no pulse_done;
//    restore interlock + fault_clear -> DISARMED; re-arm -> outputs resume.
//  5 WD_CYCLES=16, armed, no kick -> fault code 10 after 16 cycles; kick every 10 cycles -> never faults.
//  6 reset asserted mid-pulse and mid-PWM -> all outputs 0 next edge, FSM DISARMED, fault_code 00.

Source files
------------

// File: rtl/laser_pkg.sv
// Shared encodings for the multi-channel laser driver: channel modes,
// fault codes and global arm-FSM states.
package laser_pkg;

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_PWM   = 2'b01;
  localparam logic [1:0] MODE_PULSE = 2'b10;
  localparam logic [1:0] MODE_CW    = 2'b11;

  localparam logic [1:0] FC_NONE      = 2'b00;
  localparam logic [1:0] FC_INTERLOCK = 2'b01;
  localparam logic [1:0] FC_WATCHDOG  = 2'b10;

  localparam logic [1:0] ST_DISARMED = 2'b00;
  localparam logic [1:0] ST_ARMED    = 2'b01;
  localparam logic [1:0] ST_FAULT    = 2'b10;

endpackage

// File: rtl/laser_channel.sv
// One emitter channel: mode mux, registered PWM compare and the
// single-pulse counter with its busy/done handshake.
module laser_channel
  import laser_pkg::*;
#(
  parameter int PWM_W   = 8,
  parameter int PULSE_W = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [1:0]         mode_i,
  input  logic [PWM_W-1:0]   duty_i,
  input  logic [PWM_W-1:0]   pwm_cnt_i,
  input  logic               armed_i,
  input  logic               stay_armed_i,
  input  logic               pulse_start_i,
  input  logic [PULSE_W-1:0] pulse_len_i,
  output logic               raw_o,
  output logic               busy_o,
  output logic               done_o
);

  logic               raw_q, raw_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [PULSE_W-1:0] cnt_q, cnt_d;
  logic               pwm_raw;
  logic               pulse_raw;

  always_comb begin
    // All-ones duty is forced high so 100% really means every cycle.
    pwm_raw   = (&duty_i) | (pwm_cnt_i < duty_i);
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    pulse_raw = 1'b0;
    // Abort (no done strobe) when leaving PULSE mode or leaving ARMED.
    if ((mode_i != MODE_PULSE) || !stay_armed_i) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (busy_q) begin
      if (cnt_q <= PULSE_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d     = cnt_q - 1'b1;
        pulse_raw = 1'b1;
      end
    end else if (pulse_start_i && armed_i) begin
      busy_d    = 1'b1;
      cnt_d     = pulse_len_i;
      pulse_raw = |pulse_len_i;
    end

    raw_d = 1'b0;
    case (mode_i)
      MODE_PWM:   raw_d = pwm_raw;
      MODE_PULSE: raw_d = pulse_raw;
      MODE_CW:    raw_d = 1'b1;
      default:    raw_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      raw_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      raw_q  <= raw_d;
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
    end
  end

  assign raw_o  = raw_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: rtl/laser_driver_mc.sv
// Multi-channel laser driver top: global arm/interlock/watchdog FSM, shared
// PWM counter, per-channel engines and final interlock gating of the pads.
module laser_driver_mc
  import laser_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int PWM_W     = 8,
  parameter int PULSE_W   = 32,
  parameter int WD_CYCLES = 100000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      interlock_safe,
  input  logic                      arm,
  input  logic                      fault_clear,
  input  logic                      wd_kick,
  input  logic [2*NUM_CH-1:0]       ch_mode,
  input  logic [PWM_W*NUM_CH-1:0]   ch_duty,
  input  logic [NUM_CH-1:0]         pulse_start,
  input  logic [PULSE_W*NUM_CH-1:0] pulse_len,
  output logic [NUM_CH-1:0]         laser_out,
  output logic [NUM_CH-1:0]         pulse_busy,
  output logic [NUM_CH-1:0]         pulse_done,
  output logic                      armed,
  output logic                      fault,
  output logic [1:0]                fault_code
);

  localparam logic [31:0] WD_LAST = 32'(WD_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [1:0]        code_q, code_d;
  logic [31:0]       wd_q, wd_d;
  logic [PWM_W-1:0]  pwm_q;
  logic              wd_expire;
  logic              armed_now;
  logic              stay_armed;
  logic [NUM_CH-1:0] ch_raw;

  always_comb begin
    wd_expire = (WD_CYCLES != 0) && (state_q == ST_ARMED) && !wd_kick && (wd_q == WD_LAST);
    state_d   = state_q;
    code_d    = code_q;
    wd_d      = wd_q;
    case (state_q)
      ST_DISARMED: begin
        if (arm && interlock_safe) begin
          state_d = ST_ARMED;
          wd_d    = '0;
        end
      end
      ST_ARMED: begin
        wd_d = wd_kick ? '0 : wd_q + 1'b1;
        // Interlock outranks the watchdog when both hit in one cycle.
        if (!interlock_safe) begin
          state_d = ST_FAULT;
          code_d  = FC_INTERLOCK;
        end else if (wd_expire) begin
          state_d = ST_FAULT;
          code_d  = FC_WATCHDOG;
        end else if (!arm) begin
          state_d = ST_DISARMED;
        end
      end
      ST_FAULT: begin
        if (fault_clear && interlock_safe) begin
          state_d = ST_DISARMED;
          code_d  = FC_NONE;
        end
      end
      default: begin
        state_d = ST_DISARMED;
        code_d  = FC_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_DISARMED;
      code_q  <= FC_NONE;
      wd_q    <= '0;
      pwm_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      wd_q    <= wd_d;
      pwm_q   <= pwm_q + 1'b1;
    end
  end

  assign armed_now  = (state_q == ST_ARMED);
  assign stay_armed = (state_d == ST_ARMED);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    laser_channel #(
      .PWM_W   (PWM_W),
      .PULSE_W (PULSE_W)
    ) u_ch (
      .clk_i         (clk),
      .reset_i       (reset),
      .mode_i        (ch_mode[2*g +: 2]),
      .duty_i        (ch_duty[PWM_W*g +: PWM_W]),
      .pwm_cnt_i     (pwm_q),
      .armed_i       (armed_now),
      .stay_armed_i  (stay_armed),
      .pulse_start_i (pulse_start[g]),
      .pulse_len_i   (pulse_len[PULSE_W*g +: PULSE_W]),
      .raw_o         (ch_raw[g]),
      .busy_o        (pulse_busy[g]),
      .done_o        (pulse_done[g])
    );
  end

  // Combinational on interlock_safe so an interlock drop kills the pads immediately.
  assign laser_out  = ch_raw & {NUM_CH{armed_now & interlock_safe}};
  assign armed      = armed_now;
  assign fault      = (state_q == ST_FAULT);
  assign fault_code = code_q;

endmodule

// File: tb/tb_laser_driver_mc.sv
// Randomized + directed bench for laser_driver_mc against a cycle-level
// behavioural model built from absolute cycle arithmetic.
module tb_laser_driver_mc;

  localparam int NCH = 4;
  localparam int PW  = 8;
  localparam int LW  = 32;
  localparam int WD  = 16;
  localparam int S_DIS = 0, S_ARM = 1, S_FLT = 2;

  logic            clk = 1'b0;
  logic            reset, interlock_safe, arm, fault_clear, wd_kick;
  logic [2*NCH-1:0]  ch_mode;
  logic [PW*NCH-1:0] ch_duty;
  logic [NCH-1:0]    pulse_start;
  logic [LW*NCH-1:0] pulse_len;
  logic [NCH-1:0]    laser_out, pulse_busy, pulse_done;
  logic            armed, fault;
  logic [1:0]      fault_code;

  laser_driver_mc #(.NUM_CH(NCH), .PWM_W(PW), .PULSE_W(LW), .WD_CYCLES(WD)) dut (
    .clk(clk), .reset(reset), .interlock_safe(interlock_safe), .arm(arm),
    .fault_clear(fault_clear), .wd_kick(wd_kick), .ch_mode(ch_mode), .ch_duty(ch_duty),
    .pulse_start(pulse_start), .pulse_len(pulse_len), .laser_out(laser_out),
    .pulse_busy(pulse_busy), .pulse_done(pulse_done), .armed(armed), .fault(fault),
    .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  int n_total = 0, n_bad = 0;
  int e = 0;
  int m_st = S_DIS, m_code = 0, m_z = 0, m_t = 0;
  int m_busy[NCH], m_done[NCH], m_raw[NCH], m_end[NCH], m_hend[NCH];
  bit auto_kick = 1'b0;
  int n_hi, n_dn, n_any;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model of one clock edge using the inputs as they stand before the edge.
  task automatic model_edge();
    int nst, ncode, pv, m, len, duty;
    bit cur, stay, praw;
    if (reset) begin
      m_st = S_DIS; m_code = 0; m_t = 0; m_z = e;
      for (int c = 0; c < NCH; c++) begin
        m_busy[c] = 0; m_done[c] = 0; m_raw[c] = 0;
      end
      e++;
      return;
    end
    pv = m_t % (1 << PW);
    m_t++;
    nst = m_st; ncode = m_code;
    if (m_st == S_DIS) begin
      if (arm && interlock_safe) begin nst = S_ARM; m_z = e; end
    end else if (m_st == S_ARM) begin
      if (!interlock_safe) begin nst = S_FLT; ncode = 1; end
      else if (!wd_kick && (e - 1 - m_z) == WD - 1) begin nst = S_FLT; ncode = 2; end
      else if (!arm) nst = S_DIS;
      if (wd_kick) m_z = e;
    end else if (fault_clear && interlock_safe) begin
      nst = S_DIS; ncode = 0;
    end
    cur  = (m_st == S_ARM);
    stay = (nst == S_ARM);
    for (int c = 0; c < NCH; c++) begin
      m    = int'(ch_mode[2*c +: 2]);
      duty = int'(ch_duty[PW*c +: PW]);
      len  = int'(pulse_len[LW*c +: LW]);
      m_done[c] = 0;
      praw = 1'b0;
      if (m != 2 || !stay) begin
        m_busy[c] = 0;
      end else if (m_busy[c] != 0) begin
        if (e == m_end[c]) begin m_busy[c] = 0; m_done[c] = 1; end
        praw = (e < m_hend[c]);
      end else if (pulse_start[c] && cur) begin
        m_busy[c] = 1;
        m_end[c]  = e + ((len == 0) ? 1 : len);
        m_hend[c] = e + len;
        praw = (e < m_hend[c]);
      end
      case (m)
        1:       m_raw[c] = ((duty == (1 << PW) - 1) || (pv < duty)) ? 1 : 0;
        2:       m_raw[c] = praw ? 1 : 0;
        3:       m_raw[c] = 1;
        default: m_raw[c] = 0;
      endcase
    end
    m_st = nst; m_code = ncode;
    e++;
  endtask

  function automatic logic [15:0] exp_vec();
    logic [NCH-1:0] lo, bz, dn;
    logic a, f;
    a = (m_st == S_ARM);
    f = (m_st == S_FLT);
    for (int c = 0; c < NCH; c++) begin
      lo[c] = (m_raw[c] != 0) && a && interlock_safe;
      bz[c] = (m_busy[c] != 0);
      dn[c] = (m_done[c] != 0);
    end
    return {lo, bz, dn, a, f, 2'(m_code)};
  endfunction

  task automatic step();
    if (auto_kick) wd_kick = (e % 8 == 0);
    @(negedge clk);
    check("cyc", 64'({laser_out, pulse_busy, pulse_done, armed, fault, fault_code}), 64'(exp_vec()));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1'b1; interlock_safe = 1'b0; arm = 1'b0; fault_clear = 1'b0; wd_kick = 1'b0;
    ch_mode = '0; ch_duty = '0; pulse_start = '0; pulse_len = '0;
    @(posedge clk); model_edge(); #1;
    steps(2);
    check("rst_out", 64'({laser_out, pulse_busy, pulse_done, armed, fault, fault_code}), 64'd0);
    reset = 1'b0;

    // interlock open with arm requested: never arms, never emits
    arm = 1'b1; ch_mode[1:0] = 2'b11;
    n_any = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (armed || laser_out != 0) n_any++;
    end
    check("t1_noarm", 64'(n_any), 64'd0);

    // PWM duty sweep on ch0
    interlock_safe = 1'b1; auto_kick = 1'b1;
    steps(2);
    check("t2_armed", 64'(armed), 64'd1);
    ch_mode[1:0] = 2'b01;
    for (int k = 0; k < 3; k++) begin
      ch_duty[7:0] = (k == 0) ? 8'd64 : (k == 1) ? 8'd255 : 8'd0;
      steps(3);
      n_hi = 0;
      for (int i = 0; i < 256; i++) begin
        step();
        if (laser_out[0]) n_hi++;
      end
      check("t2_duty", 64'(n_hi), (k == 0) ? 64'd64 : (k == 1) ? 64'd256 : 64'd0);
    end

    // single pulses on ch1: len 1000 then len 0
    ch_mode[1:0] = 2'b00; ch_mode[3:2] = 2'b10;
    for (int k = 0; k < 2; k++) begin
      pulse_len[63:32] = (k == 0) ? 32'd1000 : 32'd0;
      steps(2);
      pulse_start[1] = 1'b1;
      n_hi = 0; n_dn = 0;
      for (int i = 0; i < 1010; i++) begin
        step();
        pulse_start[1] = 1'b0;
        if (laser_out[1]) n_hi++;
        if (pulse_done[1]) n_dn++;
      end
      check("t3_high", 64'(n_hi), (k == 0) ? 64'd1000 : 64'd0);
      check("t3_done", 64'(n_dn), 64'd1);
      check("t3_busy", 64'(pulse_busy[1]), 64'd0);
    end

    // interlock drop with ch0 CW and a pulse in flight on ch1
    ch_mode[1:0] = 2'b11; pulse_len[63:32] = 32'd50; pulse_start[1] = 1'b1;
    step();
    pulse_start[1] = 1'b0;
    steps(10);
    check("t4_pre", 64'(laser_out[1:0]), 64'd3);
    interlock_safe = 1'b0;
    #1;
    check("t4_comb", 64'(laser_out), 64'd0);
    step();
    check("t4_fault", 64'({fault, fault_code}), 64'b101);
    check("t4_abort", 64'({pulse_busy[1], pulse_done[1]}), 64'd0);
    steps(3);
    interlock_safe = 1'b1; fault_clear = 1'b1;
    step();
    fault_clear = 1'b0;
    check("t4_clr", 64'({armed, fault, fault_code}), 64'd0);
    steps(2);
    check("t4_resume", 64'({armed, laser_out[0]}), 64'b11);

    // watchdog: no kick, then kick every 10 cycles
    auto_kick = 1'b0; wd_kick = 1'b0; arm = 1'b0;
    steps(2);
    arm = 1'b1;
    n_any = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (armed) n_any++;
      if (fault) break;
    end
    check("t5_wdcyc", 64'(n_any), 64'd16);
    check("t5_wdcode", 64'({fault, fault_code}), 64'b110);
    fault_clear = 1'b1;
    step();
    fault_clear = 1'b0;
    n_any = 0;
    for (int i = 0; i < 100; i++) begin
      wd_kick = (i % 10 == 0);
      step();
      if (fault) n_any++;
    end
    wd_kick = 1'b0;
    check("t5_kicked", 64'(n_any), 64'd0);

    // reset mid-pulse and mid-PWM
    auto_kick = 1'b1;
    ch_mode[1:0] = 2'b01; ch_duty[7:0] = 8'd128;
    pulse_len[63:32] = 32'd100; pulse_start[1] = 1'b1;
    step();
    pulse_start[1] = 1'b0;
    steps(20);
    reset = 1'b1;
    step();
    check("t6_rst", 64'({laser_out, pulse_busy, pulse_done, armed, fault, fault_code}), 64'd0);
    reset = 1'b0;
    steps(2);

    // randomized traffic
    auto_kick = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      reset          = ($urandom_range(0, 499) == 0);
      interlock_safe = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 49) == 0) arm = ~arm;
      fault_clear    = ($urandom_range(0, 19) == 0);
      wd_kick        = ($urandom_range(0, 5) == 0);
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 99) == 0) ch_mode[2*c +: 2] = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 49) == 0) begin
          case ($urandom_range(0, 2))
            0:       ch_duty[PW*c +: PW] = 8'd0;
            1:       ch_duty[PW*c +: PW] = 8'd255;
            default: ch_duty[PW*c +: PW] = 8'($urandom_range(1, 254));
          endcase
        end
        if ($urandom_range(0, 9) == 0) pulse_len[LW*c +: LW] = 32'($urandom_range(0, 12));
        pulse_start[c] = ($urandom_range(0, 3) == 0);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
